// File: rtl/perceptron_pkg.sv
// Shared opcodes, FSM state type and width helpers for the perceptron front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package perceptron_pkg;

    localparam logic [1:0] OP_WR_IN   = 2'b00;
    localparam logic [1:0] OP_WR_WT   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] OP_COMPUTE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_MAC,
        ST_SEND
    } state_t;

    // Wide enough to hold n_inputs full-scale signed products without overflow.
    function automatic int acc_width(input int n_inputs, input int data_w);
        return 2 * data_w + $clog2(n_inputs);
    endfunction

    // Register-bank address width; a single-entry bank still needs one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/perceptron_if_reg_bank.sv
// Register bank with one synchronous write port and two combinational read ports.
// Latency: write visible on the edge after we; reads are same-cycle.
// Backpressure: none, always accepts writes.
module reg_bank
    import perceptron_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage: cleared on reset, written one entry per enabled cycle.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/perceptron_if.sv
// Byte-command front-end: loads input/weight banks, runs a serial MAC, returns fire bit or read-back.
// Latency: READ offers first byte 1 cycle after command; COMPUTE offers result N_INPUTS+1 cycles after.
// Backpressure: tx byte held until tx_ready; rx bytes arriving during MAC/SEND are dropped with overrun.
module perceptron_if
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8,
    parameter int THRESH   = 0
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       overrun
);

    localparam int NB    = DATA_W / 8;
    localparam int ACC_W = acc_width(N_INPUTS, DATA_W);
    localparam int AW    = idx_width(N_INPUTS);

    localparam logic [5:0]              N_IDX      = 6'(N_INPUTS);
    localparam logic [5:0]              LAST_PAY   = 6'(NB - 1);
    localparam logic signed [ACC_W-1:0] THRESH_EXT = ACC_W'(THRESH);

    state_t                    state_q,    state_d;
    logic [1:0]                op_q,       op_d;
    logic [5:0]                idx_q,      idx_d;
    logic [DATA_W-1:0]         pay_q,      pay_d;
    logic [5:0]                pay_cnt_q,  pay_cnt_d;
    logic [5:0]                mac_cnt_q,  mac_cnt_d;
    logic signed [ACC_W-1:0]   acc_q,      acc_d;
    logic [DATA_W-1:0]         tx_shift_q, tx_shift_d;
    logic [5:0]                tx_cnt_q,   tx_cnt_d;
    logic                      tx_valid_q, tx_valid_d;
    logic                      busy_q,     busy_d;
    logic                      overrun_q,  overrun_d;

    logic                      in_we, wt_we;
    logic [AW-1:0]             wr_addr, mac_addr, rd_addr;
    logic [DATA_W-1:0]         wr_data;
    logic [DATA_W-1:0]         mac_in, mac_wt, rd_in, rd_wt, rd_val;
    logic                      rd_in_range;
    logic signed [DATA_W-1:0]  mac_in_s, mac_wt_s;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;

    assign wr_addr  = AW'(idx_q);
    assign mac_addr = AW'(mac_cnt_q);
    assign rd_addr  = AW'(rx_data[4:0]);

    // Incoming byte is the low byte; earlier payload bytes shift up (MSB first).
    assign wr_data = DATA_W'({pay_q, rx_data});

    reg_bank #(.DEPTH(N_INPUTS), .WIDTH(DATA_W), .AW(AW)) u_in_bank (
        .clk     (clk),
        .nRst    (nRst),
        .we      (in_we),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr_a (mac_addr),
        .rdata_a (mac_in),
        .raddr_b (rd_addr),
        .rdata_b (rd_in)
    );

    reg_bank #(.DEPTH(N_INPUTS), .WIDTH(DATA_W), .AW(AW)) u_wt_bank (
        .clk     (clk),
        .nRst    (nRst),
        .we      (wt_we),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr_a (mac_addr),
        .rdata_a (mac_wt),
        .raddr_b (rd_addr),
        .rdata_b (rd_wt)
    );

    // Read-back value for a READ command currently on rx_data; out-of-range entries read as zero.
    assign rd_in_range = ({1'b0, rx_data[4:0]} < N_IDX);
    assign rd_val      = !rd_in_range ? '0 : (rx_data[5] ? rd_wt : rd_in);

    // Signed product, sign-extended to accumulator width.
    assign mac_in_s = mac_in;
    assign mac_wt_s = mac_wt;
    assign prod     = (2*DATA_W)'(mac_in_s) * (2*DATA_W)'(mac_wt_s);
    assign prod_ext = ACC_W'(prod);

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_shift_q[DATA_W-1 -: 8];
    assign busy     = busy_q;
    assign overrun  = overrun_q;

    // Command FSM, payload assembly, MAC stepping and TX byte sequencing.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        pay_d      = pay_q;
        pay_cnt_d  = pay_cnt_q;
        mac_cnt_d  = mac_cnt_q;
        acc_d      = acc_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_valid_d = tx_valid_q;
        overrun_d  = 1'b0;
        in_we      = 1'b0;
        wt_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    op_d  = rx_data[7:6];
                    idx_d = rx_data[5:0];
                    case (rx_data[7:6])
                        OP_WR_IN, OP_WR_WT: begin
                            state_d   = ST_PAYLOAD;
                            pay_cnt_d = '0;
                        end
                        OP_READ: begin
                            state_d    = ST_SEND;
                            tx_valid_d = 1'b1;
                            tx_cnt_d   = 6'(NB);
                            tx_shift_d = rd_val;
                        end
                        default: begin
                            state_d   = ST_MAC;
                            acc_d     = '0;
                            mac_cnt_d = '0;
                        end
                    endcase
                end
            end

            ST_PAYLOAD: begin
                if (rx_valid) begin
                    pay_d     = wr_data;
                    pay_cnt_d = pay_cnt_q + 6'd1;
                    if (pay_cnt_q == LAST_PAY) begin
                        state_d = ST_IDLE;
                        // Out-of-range targets swallow the payload without writing.
                        if (idx_q < N_IDX) begin
                            in_we = (op_q == OP_WR_IN);
                            wt_we = (op_q == OP_WR_WT);
                        end
                    end
                end
            end

            ST_MAC: begin
                overrun_d = rx_valid;
                if (mac_cnt_q < N_IDX) begin
                    acc_d     = acc_q + prod_ext;
                    mac_cnt_d = mac_cnt_q + 6'd1;
                end else begin
                    // Accumulator is final; present the fire byte in the top byte of the shifter.
                    state_d    = ST_SEND;
                    tx_valid_d = 1'b1;
                    tx_cnt_d   = 6'd1;
                    tx_shift_d = DATA_W'({7'b0, acc_q >= THRESH_EXT}) << (DATA_W - 8);
                end
            end

            ST_SEND: begin
                overrun_d = rx_valid;
                if (tx_valid_q && tx_ready) begin
                    if (tx_cnt_q == 6'd1) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        tx_shift_d = tx_shift_q << 8;
                        tx_cnt_d   = tx_cnt_q - 6'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            idx_q      <= '0;
            pay_q      <= '0;
            pay_cnt_q  <= '0;
            mac_cnt_q  <= '0;
            acc_q      <= '0;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            pay_q      <= pay_d;
            pay_cnt_q  <= pay_cnt_d;
            mac_cnt_q  <= mac_cnt_d;
            acc_q      <= acc_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule

// File: doc/perceptron_if.md
# perceptron_if

Parametrised perceptron front-end that sits between the UART byte interface (received byte/strobe, transmit byte/busy) and the rest of the design. It decodes a byte-level command stream to load N signed inputs and N signed weights into two register banks, runs a multiply-accumulate (one product per cycle), and returns a one-byte fire/no-fire result. It also supports read-back of any stored register.

## Interface
- `N_INPUTS`, default 4: number of inputs and number of weights. Range 1..32.
- `DATA_W`, default 8: signed input/weight width. Must be 8 or 16.
- `THRESH`, default 0: signed fire threshold, compared against the accumulator.
- `clk` input, 1 bit: single clock.
- `nRst` input, 1 bit: asynchronous, active-low reset.
- `rx_valid` input, 1 bit: one-cycle strobe; a received byte is present.
- `rx_data` input, 8 bits: received byte.
- `tx_ready` input, 1 bit: UART transmitter can take a byte.
- `tx_valid` output, 1 bit: a byte is offered on `tx_data`.
- `tx_data` output, 8 bits: byte to transmit.
- `busy` output, 1 bit: high in any state other than IDLE.
- `overrun` output, 1 bit: one-cycle pulse when a byte is dropped.

## Operation
- Command byte format: `[7:6]` opcode, `[5:0]` index. The number of payload bytes per value is `NB = DATA_W/8`; payload is sent MSB first.
- `00` WR_IN: the next NB bytes are written to `input[idx]`.
- `01` WR_WT: the next NB bytes are written to `weight[idx]`.
- `10` READ: `idx[5]` selects the bank (0 = inputs, 1 = weights) and `idx[4:0]` selects the entry. The block returns NB bytes, MSB first.
- `11` COMPUTE: `idx` is ignored. The block computes the sum over i of `input[i]*weight[i]` as signed values, then returns `{7'b0, acc >= THRESH}`.
- Accumulator width is `2*DATA_W + clog2(N_INPUTS)`. It never saturates or overflows.
- Out-of-range index (`idx >= N_INPUTS`):
  - On a write, the payload bytes are consumed and discarded.
  - On a read, the block returns NB zero bytes.
- State machine:
  - IDLE: a command byte moves to PAYLOAD (for WR_*), SEND (for READ), or MAC (for COMPUTE).
  - PAYLOAD: collects NB bytes, then writes the register and returns to IDLE.
  - MAC: runs for N_INPUTS cycles, then moves to SEND.
  - SEND: returns to IDLE after the last byte handshake.
- Any `rx_valid` while in MAC or SEND: the byte is dropped, `overrun` pulses for one cycle, and the state is unaffected.
- Registers have no read/compute side effects. Compute always uses the current bank contents.

## Timing
- Reset values:
  - all `input`/`weight` entries are 0;
  - `tx_valid=0`, `tx_data=0x00`, `busy=0`, `overrun=0`;
  - state is IDLE and the accumulator is 0.
- Reset applied mid-operation aborts immediately. No partial write is committed and no byte is sent.
- A byte is accepted on the clock edge where `rx_valid=1`. Bytes may arrive on back-to-back cycles.
- Write latency: the register holds the new value on the edge after the last payload byte is accepted.
- The accumulator is cleared on the command edge. MAC then covers edges 1..N_INPUTS after the command edge.
- `tx_valid` rises after edge N_INPUTS+1. Compute latency, command to `tx_valid`, is N_INPUTS+1 cycles.
- READ: `tx_valid` rises on the edge after the command byte.
- Handshake:
  - A byte transfers on an edge where `tx_valid && tx_ready`.
  - `tx_valid` and `tx_data` must stay stable until that transfer.
  - The next byte of a READ is offered on the following cycle.
  - `tx_valid` must never depend combinationally on `tx_ready`.
- `busy` is registered and tracks state: high from the edge after the command byte until return to IDLE.

## Structure
- `perceptron_pkg` contains:
  - opcode localparams `OP_WR_IN`, `OP_WR_WT`, `OP_READ`, `OP_COMPUTE`;
  - the state enum (IDLE, PAYLOAD, MAC, SEND);
  - the accumulator-width function.
- Sub-module `reg_bank`, instantiated twice (inputs and weights):
  - parameters `DEPTH`, `WIDTH`;
  - synchronous write port plus two combinational read ports, one for the MAC index and one for the READ index.
- The top level contains the command FSM, the payload shift register, the MAC datapath and the TX byte sequencer.

## Test plan
All scenarios use `N_INPUTS=4`, `DATA_W=8`, `THRESH=0`.
1. Write inputs 1, 2, 3, 4 and weights 1, 1, 1, 1, then send COMPUTE 0xC0 with `tx_ready=1` -> `tx_data=0x01` (sum 10); `tx_valid` rises 5 cycles after the command.
2. Rewrite weight[3] to 0xF5 (-11), then COMPUTE -> sum -38 -> `tx_data=0x00`.
3. Set weights 1, 1, 1, -1.5 and boundary inputs 1, 2, 3, ... to give sum exactly 0: inputs 2, 2, 0, 4 with weights 1, 1, 1, 0xFF -> `0x01`. Also check `tx_ready=0` for 20 cycles -> `tx_valid` and `tx_data` held stable.
4. Send READ 0xA2 (weight[2]) after writing 0x7E -> one byte 0x7E. Send READ 0x85 (out of range) -> 0x00.
5. Send 0x06 then 0x55 (write to input[6], out of range) -> no register changes; read-back of all entries is unchanged.
6. Inject a byte during MAC -> `overrun` pulses once and the result is unchanged. Assert `nRst` during PAYLOAD -> all outputs return to reset values and the target register stays 0.
